// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU classes, control bundle and
// the opcode decoder used by the ID stage.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } aluop_e;

   typedef struct packed {
      logic   regdst;
      logic   branch;
      logic   memread;
      logic   memtoreg;
      logic   memwrite;
      logic   alusrc;
      logic   regwrite;
      aluop_e aluop;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  legal;
      logic  uses_rt;
   } decode_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic decode_t decode(input logic [5:0] opcode);
      decode_t d;
      d       = '0;
      d.legal = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            d.ctrl.regdst   = 1'b1;
            d.ctrl.regwrite = 1'b1;
            d.ctrl.aluop    = ALU_FUNCT;
            d.uses_rt       = 1'b1;
         end
         OP_LW: begin
            d.ctrl.alusrc   = 1'b1;
            d.ctrl.memread  = 1'b1;
            d.ctrl.memtoreg = 1'b1;
            d.ctrl.regwrite = 1'b1;
         end
         OP_SW: begin
            d.ctrl.alusrc   = 1'b1;
            d.ctrl.memwrite = 1'b1;
            d.uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            d.ctrl.branch = 1'b1;
            d.ctrl.aluop  = ALU_SUB;
            d.uses_rt     = 1'b1;
         end
         OP_ADDI: begin
            d.ctrl.alusrc   = 1'b1;
            d.ctrl.regwrite = 1'b1;
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/stage2_id_hz_regfile.sv
// Register file: two combinational read ports, one write port, $0 hardwired.
// Optional same-cycle write-to-read bypass under STAGE2_ID_BYPASS_EN.
module regfile #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int RW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [RW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [RW-1:0]   raddr1,
   input  logic [RW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] mem [NREG];

   // NOTE: the array is reset because every register must read 0 after reset; this rules out a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && waddr != '0) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
      rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef STAGE2_ID_BYPASS_EN
      if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
      if (we && waddr != '0 && waddr == raddr2) rdata2 = wdata;
`endif
   end

endmodule

// File: rtl/stage2_id_hz.sv
// MIPS ID stage with ID/EX register, load-use stall, flush and illegal-opcode
// reporting. Define STAGE2_ID_BYPASS_EN for same-cycle writeback bypass.
module stage2_id_hz
   import mips_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int RW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     inst,
   input  logic            inst_valid,
   input  logic            flush,
   input  logic            regwrite,
   input  logic [RW-1:0]   wrreg,
   input  logic [XLEN-1:0] wrdata,
   output logic            stall_out,
   output logic            illegal,
   output logic            valid,
   output logic            regdst,
   output logic            branch,
   output logic            memread,
   output logic            memtoreg,
   output logic            memwrite,
   output logic            alusrc,
   output logic            regwrite_out,
   output logic [1:0]      aluop,
   output logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] data2,
   output logic [XLEN-1:0] seimm,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] id_regrs,
   output logic [XLEN-1:0] id_regrt
);

   logic [4:0] rs_f, rt_f, rd_f;
   decode_t    dec;
   ctrl_t      ctrl_q;
   logic       hazard, load_ok;

   assign rs_f = inst[25:21];
   assign rt_f = inst[20:16];
   assign rd_f = inst[15:11];
   assign dec  = decode(inst[31:26]);

   regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (regwrite),
      .waddr  (wrreg),
      .wdata  (wrdata),
      .raddr1 (rs_f[RW-1:0]),
      .raddr2 (rt_f[RW-1:0]),
      .rdata1 (id_regrs),
      .rdata2 (id_regrt)
   );

   // An illegal opcode uses no source register, so it can never raise a stall.
   assign hazard = valid && ctrl_q.memread && rt != 5'd0 && inst_valid && dec.legal &&
                   (rt == rs_f || (dec.uses_rt && rt == rt_f));
   assign stall_out = hazard && !flush;
   assign load_ok   = !flush && !hazard && inst_valid && dec.legal;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_BUBBLE;
         valid   <= 1'b0;
         illegal <= 1'b0;
         data1   <= '0;
         data2   <= '0;
         seimm   <= '0;
         rs      <= '0;
         rt      <= '0;
         rd      <= '0;
      end else begin
         ctrl_q  <= load_ok ? dec.ctrl : CTRL_BUBBLE;
         valid   <= load_ok;
         illegal <= !flush && !hazard && inst_valid && !dec.legal;
         data1   <= id_regrs;
         data2   <= id_regrt;
         seimm   <= XLEN'($signed(inst[15:0]));
         rs      <= rs_f;
         rt      <= rt_f;
         rd      <= rd_f;
      end
   end

   assign regdst       = ctrl_q.regdst;
   assign branch       = ctrl_q.branch;
   assign memread      = ctrl_q.memread;
   assign memtoreg     = ctrl_q.memtoreg;
   assign memwrite     = ctrl_q.memwrite;
   assign alusrc       = ctrl_q.alusrc;
   assign regwrite_out = ctrl_q.regwrite;
   assign aluop        = ctrl_q.aluop;

endmodule

// File: tb/tb_stage2_id_hz.sv
// Self-checking bench for stage2_id_hz: directed cases followed by random
// instruction streams compared against a behavioural model.
module tb_stage2_id_hz;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        inst_valid, flush, regwrite;
   logic [4:0]  wrreg;
   logic [31:0] wrdata;
   logic        stall_out, illegal, valid;
   logic        regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite_out;
   logic [1:0]  aluop;
   logic [31:0] data1, data2, seimm, id_regrs, id_regrt;
   logic [4:0]  rs, rt, rd;

   stage2_id_hz dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .flush(flush),
      .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata), .stall_out(stall_out),
      .illegal(illegal), .valid(valid), .regdst(regdst), .branch(branch),
      .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
      .regwrite_out(regwrite_out), .aluop(aluop), .data1(data1), .data2(data2),
      .seimm(seimm), .rs(rs), .rt(rt), .rd(rd), .id_regrs(id_regrs), .id_regrt(id_regrt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model of architectural state and of the expected ID/EX contents.
   logic [31:0] m_rf [32];
   logic        m_valid, m_illegal;
   logic [8:0]  m_ctrl;   // {regdst,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop}
   logic [31:0] m_d1, m_d2, m_seimm;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic        obs_stall;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void ref_decode(input logic [5:0] op, output logic [8:0] c,
                                      output logic legal, output logic use_rt);
      legal  = 1'b1;
      use_rt = 1'b0;
      c      = '0;
      case (op)
         6'h00:   begin c = 9'b1000001_10; use_rt = 1'b1; end
         6'h23:   c = 9'b0011011_00;
         6'h2B:   begin c = 9'b0000110_00; use_rt = 1'b1; end
         6'h04:   begin c = 9'b0100000_01; use_rt = 1'b1; end
         6'h08:   c = 9'b0000011_00;
         default: legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
`ifdef STAGE2_ID_BYPASS_EN
      if (regwrite && wrreg == r) return wrdata;
`endif
      return m_rf[r];
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   function automatic logic [31:0] radd(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      return {6'h00, s, t, d, 11'h020};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_valid = 0; m_illegal = 0; m_ctrl = '0;
      m_d1 = '0; m_d2 = '0; m_seimm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".ctrl"}, {valid, regdst, branch, memread, memtoreg, memwrite, alusrc,
                             regwrite_out, aluop, illegal}, {m_valid, m_ctrl, m_illegal});
      check({tag, ".data1"}, data1, m_d1);
      check({tag, ".data2"}, data2, m_d2);
      check({tag, ".seimm"}, seimm, m_seimm);
      check({tag, ".fields"}, {rs, rt, rd}, {m_rs, m_rt, m_rd});
   endtask

   // Starts and ends one time unit after a rising edge.
   task automatic cycle(input string tag, input logic [31:0] i, input logic iv, input logic fl,
                        input logic rw, input logic [4:0] wr, input logic [31:0] wd);
      logic [8:0]  c;
      logic        lg, ut, hz, ok;
      logic [4:0]  s, t;
      logic [31:0] r1, r2;
      inst = i; inst_valid = iv; flush = fl; regwrite = rw; wrreg = wr; wrdata = wd;
      @(negedge clk);
      s = i[25:21];
      t = i[20:16];
      ref_decode(i[31:26], c, lg, ut);
      hz = m_valid && m_ctrl[6] && m_rt != 5'd0 && iv && lg && (m_rt == s || (ut && m_rt == t));
      r1 = ref_read(s);
      r2 = ref_read(t);
      obs_stall = stall_out;
      check({tag, ".stall"}, stall_out, hz && !fl);
      check({tag, ".id_regrs"}, id_regrs, r1);
      check({tag, ".id_regrt"}, id_regrt, r2);
      ok        = !fl && !hz && iv && lg;
      m_valid   = ok;
      m_ctrl    = ok ? c : 9'd0;
      m_illegal = !fl && !hz && iv && !lg;
      m_d1 = r1; m_d2 = r2;
      m_seimm = 32'($signed(i[15:0]));
      m_rs = s; m_rt = t; m_rd = i[15:11];
      if (rw && wr != 5'd0) m_rf[wr] = wd;
      @(posedge clk); #1;
      check_regs(tag);
   endtask

   task automatic go(input string tag, input logic [31:0] i);
      cycle(tag, i, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   // Asserts reset asynchronously, holds it across one edge, releases after that edge.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, ".rst_stall"}, stall_out, 1'b0);
      check({tag, ".rst_outs"}, {valid, regdst, branch, memread, memtoreg, memwrite, alusrc,
                                regwrite_out, aluop, illegal, rs, rt, rd}, 64'd0);
      check({tag, ".rst_data"}, {data1, data2}, 64'd0);
      check({tag, ".rst_seimm"}, seimm, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0020;

   initial begin
      rst_n = 1'b1;
      inst = itype(6'h23, 5'd1, 5'd3, 16'd0); inst_valid = 1'b1;
      flush = 1'b0; regwrite = 1'b0; wrreg = '0; wrdata = '0;
      model_reset();
      @(posedge clk); #1;
      apply_reset("reset");

      // Preload a few registers via the writeback port.
      for (int r = 1; r < 8; r++)
         cycle("preload", NOP, 1'b0, 1'b0, 1'b1, 5'(r), 32'h100 * r);

      go("addi", 32'h2002FFFB);
      check("addi.seimm", seimm, 32'hFFFFFFFB);
      check("addi.flags", {valid, alusrc, regwrite_out, rt}, {3'b111, 5'd2});

      go("lw_rt", itype(6'h23, 5'd1, 5'd3, 16'd0));
      go("add_hz", radd(5'd4, 5'd3, 5'd5));
      check("lu_rt.stall", obs_stall, 1'b1);
      check("lu_rt.bubble", valid, 1'b0);
      go("add_go", radd(5'd4, 5'd3, 5'd5));
      check("lu_rt.release", obs_stall, 1'b0);
      check("lu_rt.valid", valid, 1'b1);

      go("lw_rs", itype(6'h23, 5'd1, 5'd3, 16'd0));
      go("addi_hz", itype(6'h08, 5'd3, 5'd4, 16'd1));
      check("lu_rs.stall", obs_stall, 1'b1);
      go("addi_go", itype(6'h08, 5'd3, 5'd4, 16'd1));

      go("lw_r0", itype(6'h23, 5'd1, 5'd0, 16'd0));
      go("use_r0", radd(5'd4, 5'd0, 5'd0));
      check("lu_r0.stall", obs_stall, 1'b0);

      go("lw_fl", itype(6'h23, 5'd1, 5'd3, 16'd0));
      cycle("flush_hz", radd(5'd4, 5'd3, 5'd5), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      check("flush.stall", obs_stall, 1'b0);
      check("flush.bubble", valid, 1'b0);

      go("illegal", {6'h3F, 26'h123456});
      check("illegal.pulse", {illegal, valid}, 2'b10);
      go("after_illegal", NOP);
      check("illegal.clear", illegal, 1'b0);

      cycle("wr7", NOP, 1'b0, 1'b0, 1'b1, 5'd7, 32'h11111111);
      cycle("rw7", radd(5'd1, 5'd7, 5'd0), 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
`ifdef STAGE2_ID_BYPASS_EN
      check("bypass.data1", data1, 32'hDEADBEEF);
`else
      check("nobypass.data1", data1, 32'h11111111);
`endif
      cycle("wr0", NOP, 1'b0, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D);
      go("rd0", radd(5'd1, 5'd0, 5'd0));
      check("r0.data1", data1, 32'd0);

      // Reset in the middle of a stall: the held instruction decodes cleanly after release.
      go("lw_rst", itype(6'h23, 5'd1, 5'd3, 16'd0));
      inst = radd(5'd4, 5'd3, 5'd5);
      #1;
      check("midstall.stall", stall_out, 1'b1);
      apply_reset("midstall");
      go("after_rst", radd(5'd4, 5'd3, 5'd5));
      check("after_rst.stall", obs_stall, 1'b0);
      check("after_rst.valid", valid, 1'b1);

      for (int n = 0; n < 500; n++) begin
         logic [5:0]  op;
         logic [31:0] i;
         case ($urandom_range(0, 6))
            0:       op = 6'h00;
            1, 2:    op = 6'h23;
            3:       op = 6'h2B;
            4:       op = 6'h04;
            5:       op = 6'h08;
            default: op = 6'($urandom);
         endcase
         i = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
         cycle("rand", i, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stage2_id_hz.md
# stage2_id_hz

Parametrised decode stage for the five-stage MIPS pipeline, sitting between the IF/ID and ID/EX boundaries. It decodes the instruction, reads two operands from an internal register file and registers the control and data into the ID/EX pipeline register. Beyond the basic decode stage, it adds:
- a valid bit,
- load-use hazard detection with automatic bubble insertion and an IF stall request,
- branch flush,
- illegal-opcode reporting,
- optional writeback-to-read bypass.

## Interface
- XLEN, 32: datapath width (≥16); `seimm` is sign-extended to XLEN.
- NREG, 32: register count, one of 8/16/32; register indices use the low RW = log2(NREG) bits of each 5-bit field.

Ports (registered outputs belong to the ID/EX register):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  instruction from IF/ID
- inst_valid  in  1  `inst` holds a real instruction
- flush  in  1  taken branch; kill the instruction currently in ID
- regwrite  in  1  writeback enable
- wrreg  in  RW  writeback register
- wrdata  in  XLEN  writeback data
- stall_out  out  1  combinational; IF must hold PC and IF/ID
- illegal  out  1  registered one-cycle pulse: unknown opcode decoded
- valid  out  1  ID/EX holds a real instruction
- regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite_out  out  1 each  control
- aluop  out  2  ALU operation class
- data1, data2  out  XLEN  values of `$rs` and `$rt`
- seimm  out  XLEN  sign-extended `inst[15:0]`
- rs, rt, rd  out  5  register fields, kept for forwarding
- id_regrs, id_regrt  out  XLEN  combinational diagnostic read values

## Operation
Decode table:
- opcode 0x00 (R): regdst=1, regwrite=1, aluop=10.
- 0x23 (lw): alusrc, memread, memtoreg, regwrite; aluop=00.
- 0x2B (sw): alusrc, memwrite; aluop=00.
- 0x04 (beq): branch; aluop=01.
- 0x08 (addi): alusrc, regwrite; aluop=00.
- Any other opcode is illegal.

Operand use:
- `rs` is used by every legal opcode.
- `rt` is used by R, sw and beq only.

Load-use hazard:
- Condition: `valid` & `memread` & `rt` ≠ 0, and `rt` equals a used source field of `inst`, with `inst_valid`=1.
- Response: `stall_out`=1 and a bubble is loaded into ID/EX.
- The bubble resolves the hazard, so the stall always lasts exactly one cycle.

Bubble:
- `valid`=0 and all seven 1-bit control outputs and `aluop` are 0.
- `data1`, `data2`, `seimm`, `rs`, `rt` and `rd` are still loaded.

Load priority at each edge:
1. `flush` → bubble, with `stall_out` forced to 0.
2. hazard → bubble.
3. `inst_valid`=0 → bubble.
4. Illegal opcode → bubble, and `illegal` pulses.
5. Otherwise the decoded instruction is loaded with `valid`=1.

Register file:
- Writes occur on the rising edge when `regwrite` is set and `wrreg` ≠ 0.
- Register 0 always reads 0.

## Timing
- Reset: all registered outputs, including `illegal`, are 0. All register-file entries are 0.
- Reset may be asserted mid-stall or mid-flush; the first cycle after release behaves as an empty pipeline.
- ID latency is 1 cycle: values present before edge N appear on the ID/EX outputs after edge N.
- `stall_out` is combinational from `inst` and the registered ID/EX fields. It never depends on `flush` except through the forced 0 above.
- Same-cycle writeback and read of the same register: the result depends on the bypass configuration below.

## Configuration
- STAGE2_ID_BYPASS_EN defined:
  - A read of register r in the same cycle as a write to r (r ≠ 0) returns `wrdata`, both on `data1`/`data2` and on `id_regrs`/`id_regrt`.
  - No separate WB→ID forwarding is needed.
- STAGE2_ID_BYPASS_EN undefined: same-cycle reads return the old value. The upstream ordering must then prevent the conflict.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - aluop constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10);
  - a packed control struct;
  - a decode function opcode → {control, legal, uses_rt}.
- Sub-module `regfile`: parameters XLEN and NREG, async reset, two combinational read ports, one write port, bypass under the macro.

## Test plan
- Reset: hold `rst_n`=0 with `inst`=lw → all outputs 0, `stall_out`=0. Release → first valid decode after one edge.
- `addi $2,$0,-5` (0x2002FFFB) → next cycle `valid`=1, `alusrc`=1, `regwrite_out`=1, `seimm`=0xFFFFFFFB (XLEN=32), `rt`=2.
- `lw $3,0($1)` followed by `add $4,$3,$5` → `stall_out`=1 for exactly one cycle and a bubble (`valid`=0). The add is decoded on the next edge. `lw` followed by `addi $4,$3,1` → hazard on `rs` also stalls. `lw $0` followed by a use of `$0` → no stall.
- `flush`=1 during the hazard cycle → bubble, `stall_out`=0.
- Opcode 0x3F → bubble, `illegal` pulses high for one cycle.
- Same-cycle write `$7`=0xDEADBEEF and read `$7`: with bypass, `data1`=0xDEADBEEF; without bypass, the old value. A write to `$0` leaves it reading 0.
